// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared states and constants for the multiply/divide controller
package md_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MITER,
        DABSA,
        DABSB,
        DITER,
        DFIX,
        DONE
    } md_state_e;

    localparam int   ITER = 32;
    localparam logic ADD  = 1'b0;
    localparam logic SUB  = 1'b1;

endpackage

// File: rtl/md_iter_cnt.sv
// rtl/md_iter_cnt.sv - 6-bit iteration counter with clear, increment and terminal flag
module md_iter_cnt
    import md_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [5:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= 6'd0;
        end else if (clr) begin
            cnt <= 6'd0;
        end else if (inc) begin
            cnt <= cnt + 6'd1;
        end
    end

    assign last = (cnt == 6'(ITER - 1));

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - sequential signed multiply/divide driving an external shared add/sub unit
module md_ctrl
    import md_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic        alu_opcode,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
);

    md_state_e   state, state_nx;
    logic [31:0] acc, acc_nx;      // Booth HI / divide remainder R
    logic [31:0] q, q_nx;          // Booth LO / dividend then quotient Q
    logic        qm1, qm1_nx;
    logic [31:0] opa, opa_nx;      // multiplicand
    logic [31:0] opb, opb_nx;      // divisor, becomes |B|
    logic        sdiff, sdiff_nx;
    logic [31:0] res_nx;
    logic        exc_nx;
    logic        cnt_clr, cnt_inc, cnt_last;
    logic [31:0] mul_hi, mul_lo, r_sh, q_sh;
    logic        trial_neg;

    md_iter_cnt u_iter_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            acc            <= 32'd0;
            q              <= 32'd0;
            qm1            <= 1'b0;
            opa            <= 32'd0;
            opb            <= 32'd0;
            sdiff          <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else begin
            state          <= state_nx;
            acc            <= acc_nx;
            q              <= q_nx;
            qm1            <= qm1_nx;
            opa            <= opa_nx;
            opb            <= opb_nx;
            sdiff          <= sdiff_nx;
            data_result    <= res_nx;
            data_exception <= exc_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        q_nx         = q;
        qm1_nx       = qm1;
        opa_nx       = opa;
        opb_nx       = opb;
        sdiff_nx     = sdiff;
        res_nx       = data_result;
        exc_nx       = data_exception;
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_opcode   = ADD;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        mul_hi       = {alu_result[31], alu_result[31:1]};
        mul_lo       = {alu_result[0], q[31:1]};
        r_sh         = {acc[30:0], q[31]};
        q_sh         = {q[30:0], 1'b0};
        // Unsigned compare of the shifted remainder against |B| built from the signed subtract flags
        trial_neg    = ~acc[31] & (alu_result[31] ^ alu_overflow ^ r_sh[31] ^ opb[31]);

        case (state)
            IDLE: begin
                if (ctrl_MULT) begin
                    opa_nx   = data_operandA;
                    acc_nx   = 32'd0;
                    q_nx     = data_operandB;
                    qm1_nx   = 1'b0;
                    cnt_clr  = 1'b1;
                    state_nx = MITER;
                end else if (ctrl_DIV) begin
                    if (data_operandB == 32'd0) begin
                        res_nx   = 32'd0;
                        exc_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        q_nx     = data_operandA;
                        opb_nx   = data_operandB;
                        acc_nx   = 32'd0;
                        sdiff_nx = data_operandA[31] ^ data_operandB[31];
                        state_nx = DABSA;
                    end
                end
            end
            MITER: begin
                alu_operandA = acc;
                alu_operandB = (q[0] ^ qm1) ? opa : 32'd0;
                alu_opcode   = (q[0] & ~qm1) ? SUB : ADD;
                acc_nx       = mul_hi;
                q_nx         = mul_lo;
                qm1_nx       = q[0];
                cnt_inc      = 1'b1;
                if (cnt_last) begin
                    res_nx   = mul_lo;
                    exc_nx   = ~((&mul_hi & mul_lo[31]) | ~(|mul_hi | mul_lo[31]));
                    state_nx = DONE;
                end
            end
            DABSA: begin
                alu_opcode   = SUB;
                alu_operandB = q;
                if (q[31]) q_nx = alu_result;
                state_nx = DABSB;
            end
            DABSB: begin
                alu_opcode   = SUB;
                alu_operandB = opb;
                if (opb[31]) opb_nx = alu_result;
                cnt_clr  = 1'b1;
                state_nx = DITER;
            end
            DITER: begin
                alu_operandA = r_sh;
                alu_operandB = opb;
                alu_opcode   = SUB;
                cnt_inc      = 1'b1;
                if (trial_neg) begin
                    acc_nx = r_sh;
                    q_nx   = q_sh;
                end else begin
                    acc_nx = alu_result;
                    q_nx   = q_sh | 32'd1;
                end
                if (cnt_last) state_nx = DFIX;
            end
            DFIX: begin
                alu_opcode   = SUB;
                alu_operandB = q;
                if (sdiff) begin
                    res_nx = alu_result;
                    exc_nx = 1'b0;
                end else if (q[31]) begin
                    res_nx = 32'd0;
                    exc_nx = 1'b1;
                end else begin
                    res_nx = q;
                    exc_nx = 1'b0;
                end
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - directed self-checking bench for md_ctrl with a behavioural add/sub unit
module tb_md_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic        alu_opcode;
    logic [31:0] alu_result;
    logic        alu_overflow;

    int checks = 0;
    int failures = 0;
    int lat;
    logic busy1;

    md_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow)
    );

    always #5 clock = ~clock;

    assign alu_result   = alu_opcode ? (alu_operandA - alu_operandB) : (alu_operandA + alu_operandB);
    assign alu_overflow = alu_opcode
        ? ((alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]))
        : ((alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Returns the ready latency in cycles after the start cycle (-1 on timeout), leaving time at the ready negedge
    task automatic wait_rdy(input int inject, output int l, output logic b1);
        int n = 1;
        l = -1;
        b1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (n == 1) b1 = busy;
            if (data_resultRDY) begin
                l = n;
                break;
            end
            if (n == inject) begin
                ctrl_DIV = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd0;
            end
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
            n++;
        end
    endtask

    task automatic check_after(input string tag, input logic [31:0] held);
        @(negedge clock);
        check({tag, "_rdy_low"}, data_resultRDY, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_held"}, data_result, held);
    endtask

    initial begin
        #12;
        check("rst_result", data_result, 32'd0);
        check("rst_exc", data_exception, 1'b0);
        check("rst_rdy", data_resultRDY, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alu_a", alu_operandA, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_start(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA);
        wait_rdy(0, lat, busy1);
        check("mul7x-6_busy", busy1, 1'b1);
        check("mul7x-6_lat", lat, 33);
        check("mul7x-6_res", data_result, 32'hFFFFFFD6);
        check("mul7x-6_exc", data_exception, 1'b0);
        check_after("mul7x-6", 32'hFFFFFFD6);

        do_start(1'b1, 1'b0, 32'h00010000, 32'h00010000);
        wait_rdy(0, lat, busy1);
        check("mulovf_res", data_result, 32'd0);
        check("mulovf_exc", data_exception, 1'b1);

        do_start(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_rdy(0, lat, busy1);
        check("div-7/2_lat", lat, 36);
        check("div-7/2_res", data_result, 32'hFFFFFFFD);
        check("div-7/2_exc", data_exception, 1'b0);

        do_start(1'b0, 1'b1, 32'h80000000, 32'd3);
        wait_rdy(0, lat, busy1);
        check("divmin/3_res", data_result, 32'hD5555556);
        check("divmin/3_exc", data_exception, 1'b0);

        do_start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_rdy(0, lat, busy1);
        check("div5/0_lat", lat, 1);
        check("div5/0_res", data_result, 32'd0);
        check("div5/0_exc", data_exception, 1'b1);

        do_start(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_rdy(0, lat, busy1);
        check("divmin/-1_lat", lat, 36);
        check("divmin/-1_res", data_result, 32'd0);
        check("divmin/-1_exc", data_exception, 1'b1);

        do_start(1'b1, 1'b1, 32'd5, 32'd4);
        wait_rdy(0, lat, busy1);
        check("both_lat", lat, 33);
        check("both_res", data_result, 32'd20);
        check("both_exc", data_exception, 1'b0);

        do_start(1'b1, 1'b0, 32'd3, 32'd5);
        wait_rdy(5, lat, busy1);
        check("divbusy_lat", lat, 33);
        check("divbusy_res", data_result, 32'd15);
        check_after("divbusy", 32'd15);

        do_start(1'b1, 1'b0, 32'h00001234, 32'h00005678);
        repeat (9) @(posedge clock);
        @(negedge clock);
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("arst_result", data_result, 32'd0);
        check("arst_exc", data_exception, 1'b0);
        check("arst_rdy", data_resultRDY, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_alu_a", alu_operandA, 32'd0);
        check("arst_alu_b", alu_operandB, 32'd0);
        check("arst_alu_op", alu_opcode, 1'b0);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd2;
        data_operandB = 32'd2;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rstpulse_busy", busy, 1'b0);

        do_start(1'b1, 1'b0, 32'd3, 32'd3);
        wait_rdy(0, lat, busy1);
        check("mul3x3_lat", lat, 33);
        check("mul3x3_res", data_result, 32'd9);
        check("mul3x3_exc", data_exception, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
